// File: rtl/s_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s_mem_arbiter: round-robin, lock-aware owner arbiter for a 256x8 s_memory.
// Rev 1.0
// ---------------------------------------------------------------------------
module s_mem_arbiter (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] lock,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] addr2,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] wdata2,
  input  logic [2:0] wren,
  output logic [2:0] grant,
  output logic [2:0] rvalid,
  output logic [7:0] rdata,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  input  logic [7:0] mem_q,
  output logic [1:0] owner,
  output logic       busy
);

  // Encoding chosen so the state value is directly the owner index (3 = none).
  typedef enum logic [1:0] {
    OWN0 = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    IDLE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] rr_q, rr_d;
  logic [2:0] rvalid_q, rvalid_d;

  logic [3:0] w_pend;
  logic [3:0] w_req;
  logic [3:0] w_lock;
  logic [3:0] w_wren;
  logic [1:0] w_c0, w_c1, w_c2, w_pick;
  logic       w_own;
  logic       w_access;
  logic [7:0] w_sel_addr, w_sel_data;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Index 3 is padded with zero so IDLE's encoding never selects a live bit.
  assign w_req  = {1'b0, req};
  assign w_lock = {1'b0, lock};
  assign w_wren = {1'b0, wren};
  assign w_pend = w_req | w_lock;

  assign w_c0 = rr_q;
  assign w_c1 = inc3(w_c0);
  assign w_c2 = inc3(w_c1);

  always_comb begin
    w_pick = w_c2;
    if (w_pend[w_c0])
      w_pick = w_c0;
    else if (w_pend[w_c1])
      w_pick = w_c1;
  end

  assign w_own    = (state_q != IDLE);
  assign w_access = w_own && w_req[state_q] && !reset;

  always_comb begin
    w_sel_addr = 8'd0;
    w_sel_data = 8'd0;
    case (state_q)
      OWN0: begin w_sel_addr = addr0; w_sel_data = wdata0; end
      OWN1: begin w_sel_addr = addr1; w_sel_data = wdata1; end
      OWN2: begin w_sel_addr = addr2; w_sel_data = wdata2; end
      default: begin w_sel_addr = 8'd0; w_sel_data = 8'd0; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    rvalid_d = 3'b000;
    if (state_q == IDLE) begin
      if (|w_pend)
        state_d = state_t'(w_pick);
    end else if (!w_req[state_q] && !w_lock[state_q]) begin
      state_d = IDLE;
      rr_d    = inc3(state_q);
    end
    if (w_access && !w_wren[state_q])
      rvalid_d = 3'b001 << state_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= 2'd0;
      rvalid_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign grant       = w_own ? (3'b001 << state_q) : 3'b000;
  assign owner       = state_q;
  assign busy        = |grant;
  assign rvalid      = rvalid_q;
  assign rdata       = ((|rvalid_q) && !reset) ? mem_q : 8'd0;
  assign mem_address = w_access ? w_sel_addr : 8'd0;
  assign mem_data    = w_access ? w_sel_data : 8'd0;
  assign mem_wren    = w_access && w_wren[state_q];

endmodule
`default_nettype wire
